pattern_matcher: RTL and testbench

//  Parametrised serial pattern detector; successor to the fixed 5-bit detector.

---
 rtl/pattern_matcher_if.sv | 28 ++
 rtl/pattern_matcher.sv | 69 ++++++
 tb/tb_pattern_matcher.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_matcher_if.sv
// Bus bundle for pattern_matcher: pattern programming, serial stream and match status.
interface pattern_matcher_if #(
  parameter int PATT_W = 5,
  parameter int CNT_W  = 8
);
  logic              load;
  logic [PATT_W-1:0] pattern_in;
  logic [PATT_W-1:0] mask_in;
  logic              overlap;
  logic              serial_valid;
  logic              serial_in;
  logic              patt;
  logic [CNT_W-1:0]  match_count;
  logic              count_sat;
  logic              armed;

  // Producer side: programs the pattern and drives the serial stream.
  modport master (
    output load, pattern_in, mask_in, overlap, serial_valid, serial_in,
    input  patt, match_count, count_sat, armed
  );

  // Detector side.
  modport slave (
    input  load, pattern_in, mask_in, overlap, serial_valid, serial_in,
    output patt, match_count, count_sat, armed
  );
endinterface

// File: rtl/pattern_matcher.sv
// Programmable masked serial pattern detector with overlap control and a
// saturating match counter. The newest accepted bit enters the shift register LSB,
// so pattern bit [PATT_W-1] lines up with the oldest bit of the window.
module pattern_matcher #(
  parameter int PATT_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  pattern_matcher_if.slave   bus
);
  localparam int FILL_W = $clog2(PATT_W + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PATT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [PATT_W-1:0] pat_q, mask_q, sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              patt_q, sat_q, armed_q;
  logic              hit;

  // Candidate next state for an accepted bit: shifted window, fill level, match test.
  always_comb begin
    sr_d   = {sr_q[PATT_W-2:0], bus.serial_in};
    fill_d = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
    hit    = armed_q && (fill_d == FULL) && (((sr_d ^ pat_q) & mask_q) == '0);
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // State update with priority reset > load > accepted serial bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '0;
      mask_q  <= '0;
      sr_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      patt_q  <= 1'b0;
      sat_q   <= 1'b0;
      armed_q <= 1'b0;
    end else if (bus.load) begin
      // Reprogramming discards all history; a bit presented alongside load is dropped.
      pat_q   <= bus.pattern_in;
      mask_q  <= bus.mask_in;
      armed_q <= |bus.mask_in;
      sr_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      patt_q  <= 1'b0;
    end else if (bus.serial_valid) begin
      sr_q   <= sr_d;
      // Non-overlapping mode restarts the fill so the next match needs fresh bits.
      fill_q <= (hit && !bus.overlap) ? '0 : fill_d;
      patt_q <= hit;
      if (hit) begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_MAX) sat_q <= 1'b1;
      end
    end else begin
      patt_q <= 1'b0;
    end
  end

  assign bus.patt        = patt_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
  assign bus.armed       = armed_q;
endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher: a vector table for the main modes plus
// hand-written sequences for gaps, mid-stream load/reset and counter saturation.
module tb_pattern_matcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pattern_matcher_if #(.PATT_W(5), .CNT_W(8)) ifa ();
  pattern_matcher_if #(.PATT_W(5), .CNT_W(2)) ifb ();

  pattern_matcher #(.PATT_W(5), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pattern_matcher #(.PATT_W(5), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    logic       ld;
    logic [4:0] pat;
    logic [4:0] msk;
    logic       ov;
    logic       v;
    logic       s;
    logic       e_patt;
    logic [7:0] e_cnt;
    logic       e_sat;
    logic       e_arm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic ld, input logic [4:0] p, input logic [4:0] m,
                         input logic ov, input logic v, input logic s);
    ifa.load = ld; ifa.pattern_in = p; ifa.mask_in = m;
    ifa.overlap = ov; ifa.serial_valid = v; ifa.serial_in = s;
    @(posedge clk); #1;
  endtask

  task automatic bit_a(input logic s);
    drive_a(1'b0, 5'b0, 5'b0, 1'b1, 1'b1, s);
  endtask

  task automatic idle_a();
    drive_a(1'b0, 5'b0, 5'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic bit_b(input logic s);
    ifb.load = 1'b0; ifb.serial_valid = 1'b1; ifb.serial_in = s;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic ld, input logic [4:0] p, input logic [4:0] m, input logic ov,
                     input logic v, input logic s, input logic ep, input logic [7:0] ec,
                     input logic es, input logic ea);
    vec_t r;
    r.ld = ld; r.pat = p; r.msk = m; r.ov = ov; r.v = v; r.s = s;
    r.e_patt = ep; r.e_cnt = ec; r.e_sat = es; r.e_arm = ea;
    tbl.push_back(r);
  endtask

  initial begin
    ifa.load = 0; ifa.pattern_in = 0; ifa.mask_in = 0; ifa.overlap = 0;
    ifa.serial_valid = 0; ifa.serial_in = 0;
    ifb.load = 0; ifb.pattern_in = 0; ifb.mask_in = 0; ifb.overlap = 1;
    ifb.serial_valid = 0; ifb.serial_in = 0;

    // Overlapping 11011 on stream 11011011: hits after bits 5 and 8.
    add(1, 5'b11011, 5'b11111, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 2, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 2, 0, 1);
    // Same stream, non-overlapping: only the first hit.
    add(1, 5'b11011, 5'b11111, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 1);
    // Masked 1xxx1 on stream 10101.
    add(1, 5'b10001, 5'b10001, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
    // All-zero mask: disarmed, nothing ever matches.
    add(1, 5'b11111, 5'b00000, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    // Load with a valid bit in the same cycle: that bit is dropped.
    add(1, 5'b11111, 5'b11111, 1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 1, 0, 1);

    // Reset state.
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("reset patt",  ifa.patt, 0);
    chk("reset count", ifa.match_count, 0);
    chk("reset sat",   ifa.count_sat, 0);
    chk("reset armed", ifa.armed, 0);

    foreach (tbl[i]) begin
      drive_a(tbl[i].ld, tbl[i].pat, tbl[i].msk, tbl[i].ov, tbl[i].v, tbl[i].s);
      chk($sformatf("row%0d patt", i),  ifa.patt, tbl[i].e_patt);
      chk($sformatf("row%0d count", i), ifa.match_count, tbl[i].e_cnt);
      chk($sformatf("row%0d sat", i),   ifa.count_sat, tbl[i].e_sat);
      chk($sformatf("row%0d armed", i), ifa.armed, tbl[i].e_arm);
    end

    // Gap in serial_valid keeps the partial match.
    drive_a(1'b1, 5'b11011, 5'b11111, 1'b1, 1'b0, 1'b0);
    bit_a(1); bit_a(1); bit_a(0);
    for (int i = 0; i < 3; i++) begin
      idle_a();
      chk("gap idle patt", ifa.patt, 0);
    end
    bit_a(1);
    chk("gap bit4 patt", ifa.patt, 0);
    bit_a(1);
    chk("gap bit5 patt", ifa.patt, 1);
    chk("gap count", ifa.match_count, 1);

    // Load mid-stream discards history: 5 new bits are needed.
    drive_a(1'b1, 5'b11011, 5'b11111, 1'b1, 1'b0, 1'b0);
    bit_a(1); bit_a(1); bit_a(0);
    drive_a(1'b1, 5'b11011, 5'b11111, 1'b1, 1'b0, 1'b0);
    bit_a(1);
    chk("reload b1 patt", ifa.patt, 0);
    bit_a(1);
    chk("reload b2 patt", ifa.patt, 0);
    bit_a(0); bit_a(1);
    chk("reload b4 patt", ifa.patt, 0);
    bit_a(1);
    chk("reload b5 patt", ifa.patt, 1);
    chk("reload count", ifa.match_count, 1);

    // Reset mid-stream clears everything.
    bit_a(0); bit_a(1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset armed", ifa.armed, 0);
    chk("midreset count", ifa.match_count, 0);

    // Narrow counter saturation on an all-ones stream.
    ifb.load = 1'b1; ifb.pattern_in = 5'b11111; ifb.mask_in = 5'b11111; ifb.overlap = 1'b1;
    ifb.serial_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bit_b(1);
    chk("sat pre count", ifb.match_count, 0);
    bit_b(1);
    chk("sat m1 count", ifb.match_count, 1);
    chk("sat m1 sat",   ifb.count_sat, 0);
    bit_b(1);
    chk("sat m2 count", ifb.match_count, 2);
    chk("sat m2 sat",   ifb.count_sat, 0);
    bit_b(1);
    chk("sat m3 count", ifb.match_count, 3);
    chk("sat m3 sat",   ifb.count_sat, 1);
    bit_b(1);
    chk("sat m4 count", ifb.match_count, 3);
    chk("sat m4 sat",   ifb.count_sat, 1);
    chk("sat m4 patt",  ifb.patt, 1);
    ifb.serial_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("sat reset count", ifb.match_count, 0);
    chk("sat reset sat",   ifb.count_sat, 0);
    chk("sat reset patt",  ifb.patt, 0);
    chk("sat reset armed", ifb.armed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
